// File: rtl/uart_receiver.sv
// UART receiver: 2-flop RX synchroniser, mid-bit sampling FSM, and a one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 52
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       RX,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync2_q;
    logic            rx_s;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic            wrap;
    logic            half;
    logic            cnt_clr, cnt_inc, shift_en, stop_smp, par_smp;
    logic            par_bad;
    logic            byte_ok, frame_bad;

    assign rx_s = sync2_q;
    assign wrap = (cnt_q == CNT_MAX);
    assign half = (cnt_q == CNT_HALF);

    // Synchronisers idle high so a reset never looks like a start bit by itself.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= RX;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                if (half) state_d = rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (wrap && (bit_idx_q == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (wrap) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (wrap) state_d = rx_s ? S_IDLE : S_BREAK;
            end
            S_BREAK: begin
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        shift_en = 1'b0;
        par_smp  = 1'b0;
        stop_smp = 1'b0;
        busy     = (state_q != S_IDLE);
        case (state_q)
            S_IDLE:   cnt_clr = 1'b1;
            S_START: begin
                cnt_clr = half;
                cnt_inc = !half;
            end
            S_DATA: begin
                cnt_inc  = 1'b1;
                shift_en = wrap;
            end
            S_PARITY: begin
                cnt_inc = 1'b1;
                par_smp = wrap;
            end
            S_STOP: begin
                cnt_inc  = 1'b1;
                stop_smp = wrap;
            end
            S_BREAK:  cnt_clr = 1'b1;
            default:  cnt_clr = 1'b1;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (cnt_inc) begin
            cnt_d = wrap ? '0 : cnt_q + CW'(1);
        end
    end

    always_comb begin
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        if (state_q == S_START) begin
            bit_idx_d = 3'd0;
        end else if (shift_en) begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {rx_s, shift_q[7:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_err_q, par_err_d;

    // Even parity: data bits plus parity bit must XOR to zero.
    always_comb begin
        par_err_d = par_err_q;
        if (state_q == S_START) begin
            par_err_d = 1'b0;
        end else if (par_smp) begin
            par_err_d = (^shift_q) ^ rx_s;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign par_bad = par_err_q;
`else
    assign par_bad = 1'b0;
`endif

    assign byte_ok   = stop_smp && rx_s && !par_bad;
    assign frame_bad = stop_smp && !(rx_s && !par_bad);

    // A completing byte may replace the held one only if it is consumed on the same edge.
    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        overrun_d   = 1'b0;
        frame_err_d = frame_bad;
        if (byte_ok) begin
            if (!valid_q || ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at CLKS_PER_BIT=52; event counters are kept by a negedge monitor.
module tb_uart_receiver;

    localparam int CPB = 52;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 2 + CPB / 2 + 10 * CPB + 1;
`else
    localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;
`endif

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       RX;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;

    int vrise = 0, vhigh = 0, ferr = 0, ovr = 0, rise_cyc = 0;
    logic [7:0] rise_data = 8'h00;
    logic valid_prev = 1'b0;
    int b_vrise, b_vhigh, b_ferr, b_ovr;

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .RX       (RX),
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (valid && !valid_prev) begin
            vrise     <= vrise + 1;
            rise_cyc  <= cyc;
            rise_data <= data;
        end
        if (valid)     vhigh <= vhigh + 1;
        if (frame_err) ferr  <= ferr + 1;
        if (overrun)   ovr   <= ovr + 1;
        valid_prev <= valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_vrise = vrise;
        b_vhigh = vhigh;
        b_ferr  = ferr;
        b_ovr   = ovr;
    endtask

    task automatic idle(input int n);
        RX = 1'b1;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        RX = b;
        repeat (CPB) @(posedge CLK);
        #1;
    endtask

    // Called 1 time unit after a rising edge; leaves RX at the stop-bit level.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par);
`else
        if (par === 1'bx) RX = 1'b1;
`endif
        drive_bit(stop);
    endtask

    initial begin
        RST_N = 1'b0;
        RX    = 1'b1;
        ready = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_data", 32'(data), 32'h00);
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_frame_err", 32'(frame_err), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        RST_N = 1'b1;
        idle(10);

        // 1: single frame 0x61 with ready held high
        snap();
        send_frame(8'h61, ^8'h61, 1'b1);
        idle(5);
        chk("t1_valid_pulses", 32'(vrise - b_vrise), 32'd1);
        chk("t1_valid_width", 32'(vhigh - b_vhigh), 32'd1);
        chk("t1_latency", 32'(rise_cyc - start_cyc), 32'(LAT));
        chk("t1_data", 32'(rise_data), 32'h61);
        chk("t1_frame_err", 32'(ferr - b_ferr), 32'd0);
        chk("t1_valid_after", 32'(valid), 32'd0);

        // 2: short low glitch on RX
        snap();
        RX = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        RX = 1'b1;
        chk("t2_busy_in_start", 32'(busy), 32'd1);
        repeat (25) @(posedge CLK);
        #1;
        chk("t2_busy_cleared", 32'(busy), 32'd0);
        idle(40);
        chk("t2_no_valid", 32'(vrise - b_vrise), 32'd0);
        chk("t2_no_frame_err", 32'(ferr - b_ferr), 32'd0);

        // 3: bad stop bit, held low into BREAK, then a good frame
        snap();
        send_frame(8'hA5, ^8'hA5, 1'b0);
        chk("t3_busy_in_break", 32'(busy), 32'd1);
        idle(10);
        chk("t3_busy_idle", 32'(busy), 32'd0);
        chk("t3_frame_err_once", 32'(ferr - b_ferr), 32'd1);
        chk("t3_no_valid", 32'(vrise - b_vrise), 32'd0);
        send_frame(8'h3C, ^8'h3C, 1'b1);
        idle(5);
        chk("t3_next_valid", 32'(vrise - b_vrise), 32'd1);
        chk("t3_next_data", 32'(rise_data), 32'h3C);
        chk("t3_no_extra_frame_err", 32'(ferr - b_ferr), 32'd1);

        // 4: overrun with ready low
        snap();
        ready = 1'b0;
        send_frame(8'h11, ^8'h11, 1'b1);
        idle(5);
        chk("t4_valid_held", 32'(valid), 32'd1);
        chk("t4_data_first", 32'(data), 32'h11);
        chk("t4_no_overrun_yet", 32'(ovr - b_ovr), 32'd0);
        send_frame(8'h22, ^8'h22, 1'b1);
        idle(5);
        chk("t4_overrun_once", 32'(ovr - b_ovr), 32'd1);
        chk("t4_data_kept", 32'(data), 32'h11);
        chk("t4_valid_still", 32'(valid), 32'd1);
        ready = 1'b1;
        @(posedge CLK);
        #1;
        chk("t4_valid_dropped", 32'(valid), 32'd0);
        chk("t4_single_valid", 32'(vrise - b_vrise), 32'd1);

        // 5: reset during data bit 4 of 0xFF, then 0x55
        snap();
        RX = 1'b0;
        repeat (CPB) @(posedge CLK);
        #1;
        RX = 1'b1;
        repeat (4 * CPB + 20) @(posedge CLK);
        #1;
        chk("t5_busy_mid_frame", 32'(busy), 32'd1);
        RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("t5_busy_in_reset", 32'(busy), 32'd0);
        chk("t5_valid_in_reset", 32'(valid), 32'd0);
        RST_N = 1'b1;
        idle(3 * CPB);
        chk("t5_nothing_for_ff", 32'(vrise - b_vrise), 32'd0);
        send_frame(8'h55, ^8'h55, 1'b1);
        idle(5);
        chk("t5_valid_55", 32'(vrise - b_vrise), 32'd1);
        chk("t5_data_55", 32'(rise_data), 32'h55);
        chk("t5_hold_55", 32'(data), 32'h55);
        chk("t5_no_frame_err", 32'(ferr - b_ferr), 32'd0);

        // back-to-back frames with no idle gap
        snap();
        send_frame(8'h0F, ^8'h0F, 1'b1);
        send_frame(8'hF0, ^8'hF0, 1'b1);
        idle(5);
        chk("b2b_two_valids", 32'(vrise - b_vrise), 32'd2);
        chk("b2b_last_data", 32'(rise_data), 32'hF0);
        chk("b2b_no_frame_err", 32'(ferr - b_ferr), 32'd0);

`ifdef UART_RX_PARITY_EN
        // 6: even parity good and bad
        snap();
        send_frame(8'h07, 1'b1, 1'b1);
        idle(5);
        chk("t6_parity_ok_valid", 32'(vrise - b_vrise), 32'd1);
        chk("t6_parity_ok_data", 32'(rise_data), 32'h07);
        chk("t6_parity_ok_no_err", 32'(ferr - b_ferr), 32'd0);
        snap();
        send_frame(8'h07, 1'b0, 1'b1);
        idle(5);
        chk("t6_parity_bad_err", 32'(ferr - b_ferr), 32'd1);
        chk("t6_parity_bad_no_valid", 32'(vrise - b_vrise), 32'd0);
        chk("t6_parity_bad_busy", 32'(busy), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
